// File: rtl/lcd_test_seq.sv
// lcd_test_seq: self-running LCD colour test pattern sequencer.
// Eight patterns are shown in turn, DWELL_FRAMES frames each, and the
// sequence starts on the first vs rising edge after reset. The sequence
// freezes while pause is high. Colour and lcd_de_o lag de/active_x/active_y
// by one clock.
// Optional feature: define LCD_SEQ_STEP_EN to let a step pulse request a
// manual advance. The request takes effect at the next frame boundary.
// When the macro is undefined, the step input is ignored.
module lcd_test_seq #(
  parameter int PIXEL_NUM    = 800,
  parameter int LINE_NUM     = 480,
  parameter int DWELL_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs,
  input  logic       de,
  input  logic [9:0] active_x,
  input  logic [9:0] active_y,
  input  logic       pause,
  input  logic       step,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic       lcd_de_o,
  output logic [2:0] pattern_id,
  output logic [9:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        vs_q_r;
  logic        frame_tick_s;
  logic [2:0]  pattern_r;
  logic [2:0]  pattern_next_s;
  logic [9:0]  cnt_r;
  logic [9:0]  cnt_next_s;
  logic        step_req_s;
  logic [15:0] band_full_s;
  logic [15:0] grey_full_s;
  logic [2:0]  grey_s;
  logic [15:0] colour_s;
  logic [15:0] colour_r;
  logic        de_r;

  // A frame starts on the clock where vs is high and was low one clock earlier.
  assign frame_tick_s = vs & ~vs_q_r;

`ifdef LCD_SEQ_STEP_EN
  logic pending_r;

  // A step request also counts when step arrives in the same cycle as the frame tick.
  assign step_req_s = pending_r | step;

  // Hold a step request until the next frame tick. Drop any request that arrives while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      pending_r <= 1'b0;
    end else if (frame_tick_s) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r | step;
    end
  end
`else
  logic unused_step_s;

  assign unused_step_s = step;
  assign step_req_s    = 1'b0;
`endif

  // Registers for the state, the pattern index, the frame counter and the vs history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pattern_r <= 3'd0;
      cnt_r     <= 10'd0;
      vs_q_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pattern_r <= pattern_next_s;
      cnt_r     <= cnt_next_s;
      vs_q_r    <= vs;
    end
  end

  // Next state, pattern and dwell count. These change only on a frame tick, except for pause handling.
  always_comb begin
    state_next_s   = state_r;
    pattern_next_s = pattern_r;
    cnt_next_s     = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick_s) begin
          state_next_s   = ST_SHOW;
          pattern_next_s = 3'd0;
          cnt_next_s     = 10'd0;
        end else begin
          state_next_s   = ST_IDLE;
        end
      end
      ST_SHOW, ST_HOLD: begin
        if (state_r == ST_SHOW) begin
          state_next_s = pause ? ST_HOLD : ST_SHOW;
        end else begin
          state_next_s = pause ? ST_HOLD : ST_SHOW;
        end
        if (frame_tick_s && step_req_s) begin
          // A manual step and dwell expiry in the same frame still advance the pattern by only one.
          pattern_next_s = 3'(pattern_r + 3'd1);
          cnt_next_s     = 10'd0;
        end else if (frame_tick_s && (state_r == ST_SHOW) && !pause) begin
          if (cnt_r >= 10'(DWELL_FRAMES - 1)) begin
            pattern_next_s = 3'(pattern_r + 3'd1);
            cnt_next_s     = 10'd0;
          end else begin
            cnt_next_s     = 10'(cnt_r + 10'd1);
          end
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        pattern_next_s = 3'd0;
        cnt_next_s     = 10'd0;
      end
    endcase
  end

  // Band index uses 16-bit arithmetic, so x*16 is not truncated before the divide.
  assign band_full_s = ({6'd0, active_x} << 4) / 16'(PIXEL_NUM);
  assign grey_full_s = ({6'd0, active_y} << 3) / 16'(LINE_NUM);
  assign grey_s      = (grey_full_s > 16'd7) ? 3'd7 : grey_full_s[2:0];

  // Choose the pixel colour from the current pattern. Output is black while idle.
  always_comb begin
    colour_s = 16'h0000;
    if (state_r == ST_IDLE) begin
      colour_s = 16'h0000;
    end else begin
      case (pattern_r)
        3'd0: colour_s = (band_full_s < 16'd16) ? (16'h8000 >> band_full_s[3:0]) : 16'h0000;
        3'd1: colour_s = 16'hF800;
        3'd2: colour_s = 16'h07E0;
        3'd3: colour_s = 16'h001F;
        3'd4: colour_s = 16'hFFFF;
        3'd5: colour_s = (active_x[5] ^ active_y[5]) ? 16'hFFFF : 16'h0000;
        3'd6: colour_s = {grey_s, grey_s[2:1], grey_s, grey_s, grey_s, grey_s[2:1]};
        3'd7: colour_s = 16'h0000;
        default: colour_s = 16'h0000;
      endcase
    end
  end

  // Register colour and de together. Colour is forced to black when de is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colour_r <= 16'h0000;
      de_r     <= 1'b0;
    end else begin
      colour_r <= de ? colour_s : 16'h0000;
      de_r     <= de;
    end
  end

  assign lcd_r      = colour_r[15:11];
  assign lcd_g      = colour_r[10:5];
  assign lcd_b      = colour_r[4:0];
  assign lcd_de_o   = de_r;
  assign pattern_id = pattern_r;
  assign frame_cnt  = cnt_r;

endmodule

// File: tb/tb_lcd_test_seq.sv
// Directed, table-driven bench for lcd_test_seq with DWELL_FRAMES=2.
module tb_lcd_test_seq;

  logic       clk;
  logic       rst;
  logic       vs;
  logic       de;
  logic [9:0] active_x;
  logic [9:0] active_y;
  logic       pause;
  logic       step;
  logic [4:0] lcd_r;
  logic [5:0] lcd_g;
  logic [4:0] lcd_b;
  logic       lcd_de_o;
  logic [2:0] pattern_id;
  logic [9:0] frame_cnt;

  int checks;
  int failures;

  typedef struct {
    logic [2:0]  pat;
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] colour;
    logic        de_o;
  } vec_t;

  vec_t vecs [20];

  lcd_test_seq #(
    .PIXEL_NUM(800),
    .LINE_NUM(480),
    .DWELL_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vs(vs),
    .de(de),
    .active_x(active_x),
    .active_y(active_y),
    .pause(pause),
    .step(step),
    .lcd_r(lcd_r),
    .lcd_g(lcd_g),
    .lcd_b(lcd_b),
    .lcd_de_o(lcd_de_o),
    .pattern_id(pattern_id),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic advance_to(input logic [2:0] p);
    for (int i = 0; i < 40; i++) begin
      if (pattern_id == p) break;
      vs_pulse();
    end
    check("advance_to", {29'd0, pattern_id}, {29'd0, p});
  endtask

  task automatic apply_vec(input vec_t v);
    if (pattern_id != v.pat) advance_to(v.pat);
    @(negedge clk);
    de       = v.de;
    active_x = v.x;
    active_y = v.y;
    @(negedge clk);
    check($sformatf("pat%0d_x%0d_y%0d_colour", v.pat, v.x, v.y), {16'd0, lcd_r, lcd_g, lcd_b}, {16'd0, v.colour});
    check($sformatf("pat%0d_x%0d_y%0d_de_o", v.pat, v.x, v.y), {31'd0, lcd_de_o}, {31'd0, v.de_o});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    vs       = 1'b0;
    de       = 1'b1;
    active_x = 10'd0;
    active_y = 10'd0;
    pause    = 1'b0;
    step     = 1'b0;

    vecs[0]  = '{3'd1, 1'b1, 10'd10,  10'd10,  16'hF800, 1'b1};
    vecs[1]  = '{3'd1, 1'b0, 10'd10,  10'd10,  16'h0000, 1'b0};
    vecs[2]  = '{3'd2, 1'b1, 10'd100, 10'd5,   16'h07E0, 1'b1};
    vecs[3]  = '{3'd3, 1'b1, 10'd300, 10'd200, 16'h001F, 1'b1};
    vecs[4]  = '{3'd4, 1'b1, 10'd799, 10'd479, 16'hFFFF, 1'b1};
    vecs[5]  = '{3'd5, 1'b1, 10'd32,  10'd0,   16'hFFFF, 1'b1};
    vecs[6]  = '{3'd5, 1'b1, 10'd32,  10'd32,  16'h0000, 1'b1};
    vecs[7]  = '{3'd5, 1'b1, 10'd0,   10'd0,   16'h0000, 1'b1};
    vecs[8]  = '{3'd5, 1'b1, 10'd0,   10'd40,  16'hFFFF, 1'b1};
    vecs[9]  = '{3'd6, 1'b1, 10'd0,   10'd0,   16'h0000, 1'b1};
    vecs[10] = '{3'd6, 1'b1, 10'd0,   10'd60,  16'h2124, 1'b1};
    vecs[11] = '{3'd6, 1'b1, 10'd0,   10'd300, 16'hB5B6, 1'b1};
    vecs[12] = '{3'd6, 1'b1, 10'd0,   10'd479, 16'hFFFF, 1'b1};
    vecs[13] = '{3'd7, 1'b1, 10'd0,   10'd40,  16'h0000, 1'b1};
    vecs[14] = '{3'd0, 1'b1, 10'd0,   10'd0,   16'h8000, 1'b1};
    vecs[15] = '{3'd0, 1'b1, 10'd49,  10'd0,   16'h8000, 1'b1};
    vecs[16] = '{3'd0, 1'b1, 10'd50,  10'd0,   16'h4000, 1'b1};
    vecs[17] = '{3'd0, 1'b1, 10'd799, 10'd0,   16'h0001, 1'b1};
    vecs[18] = '{3'd0, 1'b1, 10'd400, 10'd0,   16'h0080, 1'b1};
    vecs[19] = '{3'd0, 1'b0, 10'd50,  10'd0,   16'h0000, 1'b0};

    // Reset state, with de held high to show that reset overrides it.
    repeat (3) @(negedge clk);
    check("rst_colour", {16'd0, lcd_r, lcd_g, lcd_b}, 32'd0);
    check("rst_de_o", {31'd0, lcd_de_o}, 32'd0);
    check("rst_pattern", {29'd0, pattern_id}, 32'd0);
    check("rst_cnt", {22'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_black", {16'd0, lcd_r, lcd_g, lcd_b}, 32'd0);
    check("idle_de_o", {31'd0, lcd_de_o}, 32'd1);

    // Three frame ticks, dwell 2.
    vs_pulse();
    check("tick1_pat", {29'd0, pattern_id}, 32'd0);
    check("tick1_cnt", {22'd0, frame_cnt}, 32'd0);
    vs_pulse();
    check("tick2_pat", {29'd0, pattern_id}, 32'd0);
    check("tick2_cnt", {22'd0, frame_cnt}, 32'd1);
    vs_pulse();
    check("tick3_pat", {29'd0, pattern_id}, 32'd1);
    check("tick3_cnt", {22'd0, frame_cnt}, 32'd0);

    // Walk patterns 1..7.
    for (int i = 0; i < 14; i++) apply_vec(vecs[i]);

    // Wrap from 7 to 0 at dwell expiry.
    for (int i = 0; i < 4; i++) begin
      if (frame_cnt == 10'd1) break;
      vs_pulse();
    end
    check("pre_wrap_pat", {29'd0, pattern_id}, 32'd7);
    check("pre_wrap_cnt", {22'd0, frame_cnt}, 32'd1);
    vs_pulse();
    check("wrap_pat", {29'd0, pattern_id}, 32'd0);
    check("wrap_cnt", {22'd0, frame_cnt}, 32'd0);

    // Pattern 0 bands.
    for (int i = 14; i < 20; i++) apply_vec(vecs[i]);

    // Pause across five frame ticks.
    vs_pulse();
    check("prepause_cnt", {22'd0, frame_cnt}, 32'd1);
    @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) vs_pulse();
    check("pause_pat", {29'd0, pattern_id}, 32'd0);
    check("pause_cnt", {22'd0, frame_cnt}, 32'd1);
    pause = 1'b0;
    @(negedge clk);
    vs_pulse();
    check("resume_pat", {29'd0, pattern_id}, 32'd1);
    check("resume_cnt", {22'd0, frame_cnt}, 32'd0);
    vs_pulse();
    check("resume2_cnt", {22'd0, frame_cnt}, 32'd1);

    // Step pulse arriving mid-frame while frame_cnt = DWELL_FRAMES-1.
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    check("step_midframe_pat", {29'd0, pattern_id}, 32'd1);
    vs_pulse();
    check("step_expiry_pat", {29'd0, pattern_id}, 32'd2);
    check("step_expiry_cnt", {22'd0, frame_cnt}, 32'd0);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    vs_pulse();
`ifdef LCD_SEQ_STEP_EN
    check("step_only_pat", {29'd0, pattern_id}, 32'd3);
    check("step_only_cnt", {22'd0, frame_cnt}, 32'd0);
    vs_pulse();
    check("step_consumed_pat", {29'd0, pattern_id}, 32'd3);
    check("step_consumed_cnt", {22'd0, frame_cnt}, 32'd1);
`else
    check("step_ignored_pat", {29'd0, pattern_id}, 32'd2);
    check("step_ignored_cnt", {22'd0, frame_cnt}, 32'd1);
`endif

    // Asynchronous reset mid-line, followed by a fresh start.
    advance_to(3'd4);
    @(negedge clk);
    de       = 1'b1;
    active_x = 10'd5;
    active_y = 10'd5;
    @(negedge clk);
    check("pre_rst_white", {16'd0, lcd_r, lcd_g, lcd_b}, 32'h0000FFFF);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_colour", {16'd0, lcd_r, lcd_g, lcd_b}, 32'd0);
    check("async_rst_de_o", {31'd0, lcd_de_o}, 32'd0);
    check("async_rst_pat", {29'd0, pattern_id}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_idle_black", {16'd0, lcd_r, lcd_g, lcd_b}, 32'd0);
    check("post_rst_de_o", {31'd0, lcd_de_o}, 32'd1);
    active_x = 10'd0;
    vs_pulse();
    check("restart_pat", {29'd0, pattern_id}, 32'd0);
    check("restart_colour", {16'd0, lcd_r, lcd_g, lcd_b}, 32'h00008000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
